// File: rtl/sdram_pkg.sv
// Constants shared by the SDRAM controller, write data path and read capture.
// Holds the legal CAS latency / burst length values and the default bus width.
package sdram_pkg;

  localparam int SDRAM_DATA_WIDTH = 16;
  localparam int CL_MIN           = 2;
  localparam int CL_MAX           = 3;
  localparam int CL_DEFAULT       = 3;
  localparam int BL_MAX           = 8;
  localparam int BL_DEFAULT       = 1;

  function automatic bit cl_legal(input int cl);
    return (cl >= CL_MIN) && (cl <= CL_MAX);
  endfunction

  function automatic bit bl_legal(input int bl);
    return (bl == 1) || (bl == 2) || (bl == 4) || (bl == 8);
  endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// First-word-fall-through read FIFO; pointers carry one extra wrap bit so
// full/empty are resolved by comparing the pointer MSBs.
module sdram_rd_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic                  do_pop;
  logic                  do_push;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  // A full FIFO still takes a beat when the head leaves on the same edge.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sdram_read_capture.sv
// SDRAM read capture: CAS-latency delay line, burst beat counter, capture
// register and read FIFO. Define SDRAM_RD_OVF_CNT_EN to add the OVF_COUNT port.
module sdram_read_capture
  import sdram_pkg::*;
#(
  parameter int DATA_WIDTH  = SDRAM_DATA_WIDTH,
  parameter int CAS_LATENCY = CL_DEFAULT,
  parameter int BURST_LEN   = BL_DEFAULT,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  READ_ISSUE,
  input  logic [DATA_WIDTH-1:0] DQIN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic                  RD_BUSY,
  output logic                  OVERFLOW,
  input  logic                  CLR_OVF
`ifdef SDRAM_RD_OVF_CNT_EN
  ,
  output logic [7:0]            OVF_COUNT
`endif
);

  localparam int                CNT_W             = $clog2(BL_MAX + 1);
  localparam logic [CNT_W-1:0]  BEATS_AFTER_FIRST = CNT_W'(BURST_LEN - 1);

  logic [CAS_LATENCY-1:0] issue_dly_p0;
  logic [CNT_W-1:0]       beat_cnt_p0;
  logic                   issue_hit;
  logic                   capture;
  logic [DATA_WIDTH-1:0]  cap_data_p1;
  logic                   cap_vld_p1;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   drop;

  // Stage p0: latency delay line and beat counter. The counter holds the
  // beats still owed after the current one, so a reload truncates any burst.
  assign issue_hit = issue_dly_p0[CAS_LATENCY-1];
  assign capture   = issue_hit | (beat_cnt_p0 != '0);
  assign RD_BUSY   = (|issue_dly_p0) | (beat_cnt_p0 != '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      issue_dly_p0 <= '0;
      beat_cnt_p0  <= '0;
    end else begin
      issue_dly_p0 <= {issue_dly_p0[CAS_LATENCY-2:0], READ_ISSUE};
      if (issue_hit)
        beat_cnt_p0 <= BEATS_AFTER_FIRST;
      else if (beat_cnt_p0 != '0)
        beat_cnt_p0 <= beat_cnt_p0 - 1'b1;
    end
  end

  // Stage p1: capture register feeding the FIFO one edge later.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cap_vld_p1  <= 1'b0;
      cap_data_p1 <= '0;
    end else begin
      cap_vld_p1 <= capture;
      if (capture) cap_data_p1 <= DQIN;
    end
  end

  sdram_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .push      (cap_vld_p1),
    .push_data (cap_data_p1),
    .pop       (fifo_pop),
    .pop_data  (RD_DATA),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign RD_VALID = ~fifo_empty;
  assign fifo_pop = RD_VALID & RD_READY;
  assign drop     = cap_vld_p1 & fifo_full & ~fifo_pop;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      OVERFLOW <= 1'b0;
    else if (drop)
      OVERFLOW <= 1'b1;
    else if (CLR_OVF)
      OVERFLOW <= 1'b0;
  end

`ifdef SDRAM_RD_OVF_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      OVF_COUNT <= '0;
    else if (drop)
      OVF_COUNT <= sat_inc8(OVF_COUNT);
    else if (CLR_OVF)
      OVF_COUNT <= '0;
  end
`endif

endmodule

// File: tb/tb_sdram_read_capture.sv
// Directed bench for sdram_read_capture: three instances (CL3/BL4, CL2/BL4,
// CL2/BL8) sharing clock, reset, DQIN and CLR_OVF.
module tb_sdram_read_capture;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] DQIN;
  logic        CLR_OVF;

  logic        a_issue, a_ready, a_valid, a_busy, a_ovf;
  logic [15:0] a_data;
  logic        b_issue, b_ready, b_valid, b_busy, b_ovf;
  logic [15:0] b_data;
  logic        c_issue, c_ready, c_valid, c_busy, c_ovf;
  logic [15:0] c_data;
`ifdef SDRAM_RD_OVF_CNT_EN
  logic [7:0]  a_cnt, b_cnt, c_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int base   = 0;
  int r;

  always #5 CLK = ~CLK;

  sdram_read_capture #(.DATA_WIDTH(16), .CAS_LATENCY(3), .BURST_LEN(4), .FIFO_DEPTH(8)) u_a (
    .CLK(CLK), .RESET_N(RESET_N), .READ_ISSUE(a_issue), .DQIN(DQIN),
    .RD_DATA(a_data), .RD_VALID(a_valid), .RD_READY(a_ready), .RD_BUSY(a_busy),
    .OVERFLOW(a_ovf), .CLR_OVF(CLR_OVF)
`ifdef SDRAM_RD_OVF_CNT_EN
    , .OVF_COUNT(a_cnt)
`endif
  );

  sdram_read_capture #(.DATA_WIDTH(16), .CAS_LATENCY(2), .BURST_LEN(4), .FIFO_DEPTH(8)) u_b (
    .CLK(CLK), .RESET_N(RESET_N), .READ_ISSUE(b_issue), .DQIN(DQIN),
    .RD_DATA(b_data), .RD_VALID(b_valid), .RD_READY(b_ready), .RD_BUSY(b_busy),
    .OVERFLOW(b_ovf), .CLR_OVF(CLR_OVF)
`ifdef SDRAM_RD_OVF_CNT_EN
    , .OVF_COUNT(b_cnt)
`endif
  );

  sdram_read_capture #(.DATA_WIDTH(16), .CAS_LATENCY(2), .BURST_LEN(8), .FIFO_DEPTH(8)) u_c (
    .CLK(CLK), .RESET_N(RESET_N), .READ_ISSUE(c_issue), .DQIN(DQIN),
    .RD_DATA(c_data), .RD_VALID(c_valid), .RD_READY(c_ready), .RD_BUSY(c_busy),
    .OVERFLOW(c_ovf), .CLR_OVF(CLR_OVF)
`ifdef SDRAM_RD_OVF_CNT_EN
    , .OVF_COUNT(c_cnt)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // DQIN presented before relative edge e is 0x1000 + e.
  task automatic tick;
    @(posedge CLK);
    #1;
    edge_n++;
    DQIN = 16'h1000 + 16'(edge_n - base + 1);
  endtask

  function automatic int rel();
    return edge_n - base;
  endfunction

  task automatic set_base;
    base = edge_n;
    DQIN = 16'h1001;
  endtask

  task automatic tick_to(input int target);
    while (rel() < target) tick();
  endtask

  initial begin
    RESET_N = 1'b0;
    CLR_OVF = 1'b0;
    DQIN    = '0;
    a_issue = 1'b0; a_ready = 1'b0;
    b_issue = 1'b0; b_ready = 1'b0;
    c_issue = 1'b0; c_ready = 1'b0;
    tick(); tick();

    chk1 ("rst_a_valid", a_valid, 1'b0);
    chk1 ("rst_a_busy",  a_busy,  1'b0);
    chk1 ("rst_a_ovf",   a_ovf,   1'b0);
    chk16("rst_a_data",  a_data,  16'h0000);
    chk1 ("rst_b_valid", b_valid, 1'b0);
    chk16("rst_c_data",  c_data,  16'h0000);
    RESET_N = 1'b1;
    tick();

    // CL=3, BL=4, read at edge 10: beats 0x100D..0x1010 after edges 14..17
    a_ready = 1'b1;
    set_base();
    tick_to(9);
    a_issue = 1'b1;
    tick();
    a_issue = 1'b0;
    chk1("a_busy_e10", a_busy, 1'b1);
    tick_to(13);
    chk1("a_valid_e13", a_valid, 1'b0);
    chk1("a_busy_e13",  a_busy,  1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1 ("a_valid_beat", a_valid, 1'b1);
      chk16("a_data_beat",  a_data,  16'h100D + 16'(k));
      if (k == 1) chk1("a_busy_e15", a_busy, 1'b1);
      if (k == 2) chk1("a_busy_e16", a_busy, 1'b0);
    end
    tick();
    chk1("a_valid_e18", a_valid, 1'b0);

    // CL=2, BL=4, reads at edges 10 and 12: 2 + 4 contiguous beats
    b_ready = 1'b1;
    set_base();
    tick_to(9);
    b_issue = 1'b1;
    tick();
    b_issue = 1'b0;
    tick();
    b_issue = 1'b1;
    tick();
    b_issue = 1'b0;
    chk1("b_valid_e12", b_valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk1 ("b_valid_int", b_valid, 1'b1);
      chk16("b_data_int",  b_data,  16'h100C + 16'(k));
    end
    tick();
    chk1("b_valid_after_int", b_valid, 1'b0);
    chk1("b_busy_after_int",  b_busy,  1'b0);

    // Three BL=4 reads with RD_READY low: 8 buffered, 4 dropped
    b_ready = 1'b0;
    set_base();
    b_issue = 1'b1; tick(); b_issue = 1'b0;
    tick_to(4);
    b_issue = 1'b1; tick(); b_issue = 1'b0;
    tick_to(8);
    b_issue = 1'b1; tick(); b_issue = 1'b0;
    tick_to(11);
    chk1("ovf_before_full_push", b_ovf,   1'b0);
    chk1("valid_buffered",       b_valid, 1'b1);
    tick();
    chk1("ovf_first_drop", b_ovf, 1'b1);
    tick_to(16);
    chk1 ("ovf_sticky",  b_ovf,  1'b1);
    chk1 ("busy_done",   b_busy, 1'b0);
    chk16("head_oldest", b_data, 16'h1003);
`ifdef SDRAM_RD_OVF_CNT_EN
    chk16("ovf_count", 16'(b_cnt), 16'd4);
`endif
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    chk1("ovf_cleared", b_ovf, 1'b0);
`ifdef SDRAM_RD_OVF_CNT_EN
    chk16("ovf_count_cleared", 16'(b_cnt), 16'd0);
`endif

    // Full FIFO, reader active during the capture: push and pop together
    b_issue = 1'b1;
    tick();
    b_issue = 1'b0;
    r = rel();
    tick_to(r + 2);
    b_ready = 1'b1;
    tick_to(r + 6);
    b_ready = 1'b0;
    chk1 ("full_pushpop_ovf",  b_ovf,   1'b0);
    chk1 ("full_pushpop_vld",  b_valid, 1'b1);
    chk16("full_pushpop_head", b_data,  16'h1007);
    tick();
    chk1("full_pushpop_ovf2", b_ovf, 1'b0);
    b_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk16("drain_data", b_data,
            (k < 4) ? 16'h1007 + 16'(k) : 16'h1000 + 16'(r + 2 + k - 4));
      tick();
    end
    chk1("drain_empty", b_valid, 1'b0);
    b_ready = 1'b0;

    // CL=2, BL=8: reset mid-burst, then a clean read afterwards
    c_ready = 1'b1;
    set_base();
    c_issue = 1'b1;
    tick();
    c_issue = 1'b0;
    tick_to(5);
    chk1 ("c_valid_midburst", c_valid, 1'b1);
    chk16("c_data_midburst",  c_data,  16'h1004);
    #1;
    RESET_N = 1'b0;
    #1;
    chk1 ("c_rst_valid", c_valid, 1'b0);
    chk1 ("c_rst_busy",  c_busy,  1'b0);
    chk1 ("c_rst_ovf",   c_ovf,   1'b0);
    chk16("c_rst_data",  c_data,  16'h0000);
    tick(); tick();
    RESET_N = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk1("c_no_stale", c_valid, 1'b0);
    end
    chk1("c_idle_busy", c_busy, 1'b0);
    c_issue = 1'b1;
    tick();
    c_issue = 1'b0;
    r = rel();
    tick_to(r + 2);
    chk1("c_post_rst_pre", c_valid, 1'b0);
    tick();
    chk1 ("c_post_rst_valid", c_valid, 1'b1);
    chk16("c_post_rst_data",  c_data,  16'h1000 + 16'(r + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
